imem_fetch_ctrl: RTL and testbench

Parametrised instruction memory with a boot-time program-load port and a valid/ready fetch interface. After reset it accepts a program stream into its array, then serves fetches with a one-cycle registered read. Misaligned and out-of-program fetches are flagged and answered with a NOP. It sits between the loader/testbench and the core's fetch stage, and replaces the fixed combinational ROM.

---
 rtl/imem_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
`timescale 1ns/1ps
// Instruction memory: boot-time program load, then valid/ready instruction fetch with NOP-on-fault.
// Latency: fetch response registered exactly one cycle after request accept; load writes land on the accepting edge.
// Backpressure: a stalled response (valid && !ready) holds instr/fault and blocks new requests; load_ready only in LOAD.
module imem_fetch_ctrl #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  // program load port
  input  logic                     load_valid,
  input  logic [31:0]              load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic [$clog2(DEPTH):0]   load_count,
  output logic                     load_overflow,
  // fetch request
  input  logic                     fetch_req_valid,
  output logic                     fetch_req_ready,
  input  logic [XLEN-1:0]          fetch_addr,
  // fetch response
  output logic                     fetch_resp_valid,
  input  logic                     fetch_resp_ready,
  output logic [31:0]              fetch_instr,
  output logic [1:0]               fetch_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   load_count_q, load_count_d;
  logic            load_overflow_q, load_overflow_d;
  logic            mem_we;

  logic [31:0]     mem_q [DEPTH];

  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [1:0]      fault_q, fault_d;

  logic            accept;
  logic [XLEN-1:0] word_addr;
  logic [XLEN-1:0] count_ext;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_word;
  logic            misaligned;
  logic            out_of_range;

  // LOAD accepts program words; RUN serves fetches. Only reset brings us back to LOAD.
  assign load_ready      = (state_q == ST_LOAD);
  assign fetch_req_ready = (state_q == ST_RUN) && (!resp_valid_q || fetch_resp_ready);
  assign accept          = fetch_req_valid && fetch_req_ready;

  assign load_count       = load_count_q;
  assign load_overflow    = load_overflow_q;
  assign fetch_resp_valid = resp_valid_q;
  assign fetch_instr      = instr_q;
  assign fetch_fault      = fault_q;

  // Address decode. The range check uses the full byte address so that any
  // upper bits beyond the array are caught instead of aliasing into it.
  assign word_addr    = fetch_addr >> 2;
  assign count_ext    = XLEN'(load_count_q);
  assign misaligned   = |fetch_addr[1:0];
  assign out_of_range = (word_addr >= count_ext);
  assign rd_idx       = fetch_addr[AW+1:2];
  assign rd_word      = mem_q[rd_idx];

  // Load sequencing and FSM next state: store while room remains, otherwise
  // drop the word and flag overflow; load_last ends loading either way.
  always_comb begin
    state_d         = state_q;
    load_count_d    = load_count_q;
    load_overflow_d = load_overflow_q;
    mem_we          = 1'b0;
    if (state_q == ST_LOAD && load_valid) begin
      if (load_count_q < CW'(DEPTH)) begin
        mem_we       = 1'b1;
        load_count_d = load_count_q + CW'(1);
      end else begin
        load_overflow_d = 1'b1;
      end
      if (load_last) begin
        state_d = ST_RUN;
      end
    end
  end

  // Response next state: capture on accept, drop valid when consumed with no
  // new accept; instr/fault keep their last value otherwise.
  always_comb begin
    resp_valid_d = resp_valid_q;
    instr_d      = instr_q;
    fault_d      = fault_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      fault_d      = {out_of_range, misaligned};
      instr_d      = (out_of_range || misaligned) ? NOP_WORD : rd_word;
    end else if (fetch_resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_LOAD;
      load_count_q    <= '0;
      load_overflow_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      instr_q         <= NOP_WORD;
      fault_q         <= 2'b00;
    end else begin
      state_q         <= state_d;
      load_count_q    <= load_count_d;
      load_overflow_q <= load_overflow_d;
      resp_valid_q    <= resp_valid_d;
      instr_q         <= instr_d;
      fault_q         <= fault_d;
    end
  end

  // Instruction array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[load_count_q[AW-1:0]] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
`timescale 1ns/1ps
// Directed bench for imem_fetch_ctrl: a DEPTH=256 instance for load/fetch/fault/
// backpressure/reset sequences and a DEPTH=4 instance for load overflow.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;

  // DEPTH=256 instance
  logic        load_valid, load_last, load_ready, load_overflow;
  logic [31:0] load_data;
  logic [8:0]  load_count;
  logic        fetch_req_valid, fetch_req_ready, fetch_resp_valid, fetch_resp_ready;
  logic [31:0] fetch_addr, fetch_instr;
  logic [1:0]  fetch_fault;

  // DEPTH=4 instance
  logic        s_load_valid, s_load_last, s_load_ready, s_load_overflow;
  logic [31:0] s_load_data;
  logic [2:0]  s_load_count;
  logic        s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
  logic [31:0] s_addr, s_instr;
  logic [1:0]  s_fault;

  int nvec = 0;
  int nerr = 0;

  // reference model state for the DEPTH=256 instance
  logic [31:0] mmem [256];
  int          mcount = 0;
  bit          mrun = 0;
  logic [33:0] sbq [$];

  always #5 clk = ~clk;

  imem_fetch_ctrl #(.DEPTH(256), .XLEN(32), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_count(load_count), .load_overflow(load_overflow),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready), .fetch_addr(fetch_addr),
    .fetch_resp_valid(fetch_resp_valid), .fetch_resp_ready(fetch_resp_ready),
    .fetch_instr(fetch_instr), .fetch_fault(fetch_fault)
  );

  imem_fetch_ctrl #(.DEPTH(4), .XLEN(32), .NOP_WORD(NOP)) dut4 (
    .clk(clk), .reset(reset),
    .load_valid(s_load_valid), .load_data(s_load_data), .load_last(s_load_last),
    .load_ready(s_load_ready), .load_count(s_load_count), .load_overflow(s_load_overflow),
    .fetch_req_valid(s_req_valid), .fetch_req_ready(s_req_ready), .fetch_addr(s_addr),
    .fetch_resp_valid(s_resp_valid), .fetch_resp_ready(s_resp_ready),
    .fetch_instr(s_instr), .fetch_fault(s_fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected {instr, fault[1], fault[0]} for a fetch of byte address a
  function automatic logic [33:0] model(input logic [31:0] a);
    logic        mis, oor;
    logic [31:0] w;
    mis = (a[1:0] != 2'b00);
    w   = a >> 2;
    oor = (w >= 32'(mcount));
    model = {((mis || oor) ? NOP : mmem[w[7:0]]), oor, mis};
  endfunction

  // one cycle with current fetch inputs; push expectation on accept, pop at response
  task automatic step(input string tag, input logic exp_acc);
    logic        acc;
    logic [33:0] e;
    #1;
    acc = fetch_req_valid && fetch_req_ready;
    if (fetch_req_valid) chk({tag, "_acc"}, acc, exp_acc);
    if (acc) sbq.push_back(model(fetch_addr));
    @(posedge clk); #1;
    if (acc) begin
      e = sbq.pop_front();
      chk({tag, "_vld"},   fetch_resp_valid, 1);
      chk({tag, "_instr"}, fetch_instr, e[33:2]);
      chk({tag, "_fault"}, fetch_fault, e[1:0]);
    end
  endtask

  // one load-port cycle on the DEPTH=256 instance
  task automatic load(input logic [31:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    #1;
    if (!mrun && fetch_req_valid) chk("load_blocks_req", fetch_req_ready, 0);
    if (!mrun && mcount < 256) begin
      mmem[mcount] = d;
      mcount++;
    end
    @(posedge clk); #1;
    if (!mrun && last) mrun = 1;
    chk("load_count", load_count, mcount);
    if (fetch_req_valid) chk("load_no_resp", fetch_resp_valid, 0);
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prog [6];
    prog[0] = 32'h00300293; prog[1] = 32'h00400313; prog[2] = 32'h005303b3;
    prog[3] = 32'h40530433; prog[4] = 32'h00732623; prog[5] = 32'h0082a8a3;

    reset = 1'b1;
    load_valid = 0; load_data = 0; load_last = 0;
    fetch_req_valid = 0; fetch_addr = 0; fetch_resp_ready = 1;
    s_load_valid = 0; s_load_data = 0; s_load_last = 0;
    s_req_valid = 0; s_addr = 0; s_resp_ready = 1;
    repeat (2) @(posedge clk);
    #1;

    // reset values
    chk("rst_load_ready", load_ready, 1);
    chk("rst_load_count", load_count, 0);
    chk("rst_overflow",   load_overflow, 0);
    chk("rst_req_ready",  fetch_req_ready, 0);
    chk("rst_resp_valid", fetch_resp_valid, 0);
    chk("rst_instr",      fetch_instr, NOP);
    chk("rst_fault",      fetch_fault, 0);
    chk("rst4_count",     s_load_count, 0);
    reset = 1'b0;

    // load 6 words while a fetch is requested during LOAD
    fetch_req_valid = 1'b1; fetch_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) fetch_req_valid = 1'b0;
      load(prog[i], (i == 5));
    end
    chk("run_load_count", load_count, 6);
    chk("run_load_ready", load_ready, 0);
    chk("run_req_ready",  fetch_req_ready, 1);
    chk("run_no_resp",    fetch_resp_valid, 0);

    // load_valid in RUN is ignored
    load(32'hDEADBEEF, 1'b1);
    chk("run_ignore_load", load_count, 6);

    // back-to-back fetches, one per cycle
    fetch_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fetch_addr = 32'(i * 4);
      step("b2b", 1);
    end

    // faults, including a combined fault and a high address aliasing index 0
    fetch_addr = 32'h2;        step("f_mis", 1);
    fetch_addr = 32'h18;       step("f_rng", 1);
    fetch_addr = 32'h400;      step("f_far", 1);
    fetch_addr = 32'h1A;       step("f_both", 1);
    fetch_addr = 32'h80000000; step("f_high", 1);
    fetch_req_valid = 1'b0;
    step("drain", 0);
    chk("drain_vld",   fetch_resp_valid, 0);
    chk("drain_instr", fetch_instr, NOP);

    // backpressure
    fetch_resp_ready = 1'b0;
    fetch_req_valid  = 1'b1; fetch_addr = 32'h4;
    step("bp0", 1);
    fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req_ready", fetch_req_ready, 0);
      @(posedge clk); #1;
      chk("bp_hold_instr", fetch_instr, 32'h00400313);
      chk("bp_hold_vld",   fetch_resp_valid, 1);
      chk("bp_hold_fault", fetch_fault, 0);
    end
    fetch_resp_ready = 1'b1;
    step("bp1", 1);
    chk("bp1_word", fetch_instr, 32'h005303b3);
    fetch_req_valid = 1'b0;
    step("bp_idle", 0);
    chk("bp_drain_vld",  fetch_resp_valid, 0);
    chk("bp_keep_instr", fetch_instr, 32'h005303b3);

    // overflow on the DEPTH=4 instance
    for (int i = 0; i < 5; i++) begin
      s_load_valid = 1'b1; s_load_data = 32'h11110000 + 32'(i); s_load_last = (i == 4);
      @(posedge clk); #1;
    end
    s_load_valid = 1'b0; s_load_last = 1'b0;
    chk("ovf_count",     s_load_count, 4);
    chk("ovf_flag",      s_load_overflow, 1);
    chk("ovf_run",       s_load_ready, 0);
    chk("ovf_req_ready", s_req_ready, 1);
    s_req_valid = 1'b1; s_addr = 32'hC;
    @(posedge clk); #1;
    chk("ovf_last_vld",   s_resp_valid, 1);
    chk("ovf_last_instr", s_instr, 32'h11110003);
    chk("ovf_last_fault", s_fault, 0);
    s_addr = 32'h10;
    @(posedge clk); #1;
    chk("ovf_rng_instr", s_instr, NOP);
    chk("ovf_rng_fault", s_fault, 2'b10);
    s_req_valid = 1'b0;

    // reset while a response is stalled
    fetch_resp_ready = 1'b0;
    fetch_req_valid  = 1'b1; fetch_addr = 32'h0;
    step("stall", 1);
    fetch_req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_vld",   fetch_resp_valid, 0);
    chk("mid_rst_ready", load_ready, 1);
    chk("mid_rst_count", load_count, 0);
    chk("mid_rst_instr", fetch_instr, NOP);
    reset = 1'b0;
    mcount = 0; mrun = 0; sbq.delete();
    fetch_resp_ready = 1'b1;
    load(32'hAAAA0001, 1'b0);
    load(32'hBBBB0002, 1'b1);
    fetch_req_valid = 1'b1;
    fetch_addr = 32'h4; step("reload_w1", 1);
    chk("reload_w1_word", fetch_instr, 32'hBBBB0002);
    fetch_addr = 32'h0; step("reload_w0", 1);
    fetch_addr = 32'h8; step("reload_rng", 1);
    fetch_req_valid = 1'b0;
    step("end_idle", 0);
    chk("queue_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
